// File: rtl/door_ctrl_param_pkg.sv
// Shared encodings for the car-door controller: direction codes, door states,
// hall-call bit positions and the hall-call direction match.
package door_ctrl_param_pkg;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DOWN = 2'b01;

  localparam int HALL_UP_BIT = 1;
  localparam int HALL_DN_BIT = 0;

  typedef enum logic [1:0] {
    DOOR_CLOSED  = 2'b00,
    DOOR_OPENING = 2'b01,
    DOOR_OPEN    = 2'b11,
    DOOR_CLOSING = 2'b10
  } door_state_e;

  // A stopped car answers either hall direction; the illegal code answers none.
  function automatic logic hall_hit(input logic [1:0] dir, input logic [1:0] hall);
    case (dir)
      DIR_UP:   return hall[HALL_UP_BIT];
      DIR_DOWN: return hall[HALL_DN_BIT];
      DIR_STOP: return |hall;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/door_ctrl_param_if.sv
// Signal bundle between the scheduler/call latches (master) and the door
// controller (slave).
interface door_ctrl_param_if #(
  parameter int NUM_FLOORS = 7
);
  import door_ctrl_param_pkg::*;

  localparam int FLOOR_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

  logic                  moving;
  logic [FLOOR_W-1:0]    cur_floor;
  logic [1:0]            cur_dir;
  logic [1:0]            hall_btn;
  logic [NUM_FLOORS-1:0] car_call;
  logic                  open_btn;
  logic                  close_btn;
  logic                  obstruct;

  door_state_e           door_state;
  logic                  door_closed;
  logic                  served;
  logic                  nudge;
  logic                  fault;

  modport master (
    output moving, cur_floor, cur_dir, hall_btn, car_call,
           open_btn, close_btn, obstruct,
    input  door_state, door_closed, served, nudge, fault
  );

  modport slave (
    input  moving, cur_floor, cur_dir, hall_btn, car_call,
           open_btn, close_btn, obstruct,
    output door_state, door_closed, served, nudge, fault
  );

endinterface

// File: rtl/door_ctrl_param_door_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module door_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/door_ctrl_param.sv
// Car-door controller: door motion FSM with obstruction reversal, bounded
// reopen count with nudge close, and a move interlock against the scheduler.
module door_ctrl_param
  import door_ctrl_param_pkg::*;
#(
  parameter int NUM_FLOORS = 7,
  parameter int TRAVEL_CYC = 4,
  parameter int DWELL_CYC  = 10,
  parameter int MAX_REOPEN = 3,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              reset,
  door_ctrl_param_if.slave bus
);

  localparam int FLOOR_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam int RCNT_W  = $clog2(MAX_REOPEN + 2);
  localparam logic [CNT_W-1:0]  TRAVEL_VAL = CNT_W'(TRAVEL_CYC - 1);
  localparam logic [CNT_W-1:0]  DWELL_VAL  = CNT_W'(DWELL_CYC - 1);
  localparam logic [RCNT_W-1:0] REOPEN_MAX = RCNT_W'(MAX_REOPEN);

  door_state_e       state;
  logic              door_closed;
  logic              served;
  logic              nudge;
  logic              fault;
  logic [RCNT_W-1:0] reopen_cnt;

  logic floor_ok, car_hit, call_here;
  logic intl, req_open, opening_done, open_hold, open_close;
  logic reopen_req, reversal, close_done, to_closing_intl;
  logic tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;

  // Floor indices past the top floor match nothing, including hall calls.
  always_comb begin
    floor_ok = 1'b0;
    car_hit  = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (bus.cur_floor == FLOOR_W'(i)) begin
        floor_ok = 1'b1;
        car_hit  = bus.car_call[i];
      end
    end
  end

  assign call_here = floor_ok & (car_hit | hall_hit(bus.cur_dir, bus.hall_btn));

  always_comb begin
    intl            = bus.moving && (state != DOOR_CLOSED);
    to_closing_intl = intl && ((state == DOOR_OPENING) || (state == DOOR_OPEN));
    req_open        = (state == DOOR_CLOSED) && !bus.moving && (call_here || bus.open_btn);
    opening_done    = (state == DOOR_OPENING) && !intl && tmr_done;
    open_hold       = (state == DOOR_OPEN) && !intl &&
                      (bus.obstruct || bus.open_btn || call_here);
    open_close      = (state == DOOR_OPEN) && !intl && !open_hold &&
                      (bus.close_btn || tmr_done);
    reopen_req      = (state == DOOR_CLOSING) && !intl && !nudge &&
                      (bus.obstruct || bus.open_btn);
    reversal        = reopen_req && (reopen_cnt < REOPEN_MAX);
    close_done      = (state == DOOR_CLOSING) && !reversal && tmr_done;
    tmr_load        = req_open || opening_done || open_hold || open_close ||
                      reversal || to_closing_intl;
    tmr_val         = (opening_done || open_hold) ? DWELL_VAL : TRAVEL_VAL;
  end

  door_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= DOOR_CLOSED;
      door_closed <= 1'b1;
      served      <= 1'b0;
      nudge       <= 1'b0;
      fault       <= 1'b0;
      reopen_cnt  <= '0;
    end else begin
      served <= 1'b0;
      if (intl) begin
        fault <= 1'b1;
        nudge <= 1'b1;
      end
      case (state)
        DOOR_CLOSED: begin
          if (req_open) begin
            state       <= DOOR_OPENING;
            door_closed <= 1'b0;
            served      <= call_here;
            if (call_here)
              reopen_cnt <= '0;
          end
        end
        DOOR_OPENING: begin
          if (to_closing_intl)
            state <= DOOR_CLOSING;
          else if (opening_done)
            state <= DOOR_OPEN;
        end
        DOOR_OPEN: begin
          if (to_closing_intl || open_close)
            state <= DOOR_CLOSING;
        end
        DOOR_CLOSING: begin
          // Fault and nudge set by the interlock this cycle are overridden on close.
          if (reversal) begin
            state      <= DOOR_OPENING;
            reopen_cnt <= reopen_cnt + RCNT_W'(1);
          end else if (close_done) begin
            state       <= DOOR_CLOSED;
            door_closed <= 1'b1;
            nudge       <= 1'b0;
            fault       <= 1'b0;
          end else if (reopen_req) begin
            nudge <= 1'b1;
          end
        end
        default: begin
          state       <= DOOR_CLOSED;
          door_closed <= 1'b1;
        end
      endcase
    end
  end

  assign bus.door_state  = state;
  assign bus.door_closed = door_closed;
  assign bus.served      = served;
  assign bus.nudge       = nudge;
  assign bus.fault       = fault;

endmodule

// File: tb/tb_door_ctrl_param.sv
// Directed-vector bench for door_ctrl_param: each stimulus cycle queues the
// hand-derived outputs expected after the next edge; a monitor pops and compares.
module tb_door_ctrl_param;
  import door_ctrl_param_pkg::*;

  localparam int NUM_FLOORS = 7;

  typedef struct packed {
    door_state_e st;
    logic        cl;
    logic        sv;
    logic        nd;
    logic        ft;
  } obs_t;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;
  obs_t exp_q[$];

  door_ctrl_param_if #(.NUM_FLOORS(NUM_FLOORS)) bus ();

  door_ctrl_param #(
    .NUM_FLOORS (NUM_FLOORS),
    .TRAVEL_CYC (4),
    .DWELL_CYC  (10),
    .MAX_REOPEN (2),
    .CNT_W      (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input door_state_e st, input logic sv, input logic nd, input logic ft);
    obs_t e;
    e.st = st;
    e.cl = (st == DOOR_CLOSED);
    e.sv = sv;
    e.nd = nd;
    e.ft = ft;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic ticks(input int n, input door_state_e st, input logic sv,
                       input logic nd, input logic ft);
    for (int k = 0; k < n; k++) tick(st, sv, nd, ft);
  endtask

  task automatic check_now(input string tag, input door_state_e st, input logic sv,
                           input logic nd, input logic ft);
    obs_t e, a;
    e.st = st;
    e.cl = (st == DOOR_CLOSED);
    e.sv = sv;
    e.nd = nd;
    e.ft = ft;
    a.st = bus.door_state;
    a.cl = bus.door_closed;
    a.sv = bus.served;
    a.nd = bus.nudge;
    a.ft = bus.fault;
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got st=%b closed=%b served=%b nudge=%b fault=%b, want st=%b closed=%b served=%b nudge=%b fault=%b",
               tag, a.st, a.cl, a.sv, a.nd, a.ft, e.st, e.cl, e.sv, e.nd, e.ft);
    end
  endtask

  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a.st = bus.door_state;
        a.cl = bus.door_closed;
        a.sv = bus.served;
        a.nd = bus.nudge;
        a.ft = bus.fault;
        step_no++;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL step%0d: got st=%b closed=%b served=%b nudge=%b fault=%b, want st=%b closed=%b served=%b nudge=%b fault=%b",
                   step_no, a.st, a.cl, a.sv, a.nd, a.ft, e.st, e.cl, e.sv, e.nd, e.ft);
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.moving    = 1'b0;
    bus.cur_floor = 3'd3;
    bus.cur_dir   = DIR_STOP;
    bus.hall_btn  = 2'b00;
    bus.car_call  = '0;
    bus.open_btn  = 1'b0;
    bus.close_btn = 1'b0;
    bus.obstruct  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tick(DOOR_CLOSED, 0, 0, 0);
    check_now("reset_state", DOOR_CLOSED, 0, 0, 0);
    reset = 1'b0;
    tick(DOOR_CLOSED, 0, 0, 0);

    // Car call at floor 3, full open/dwell/close cycle.
    bus.car_call = 7'b0001000;
    tick(DOOR_OPENING, 1, 0, 0);
    bus.car_call = '0;
    ticks(3, DOOR_OPENING, 0, 0, 0);
    ticks(10, DOOR_OPEN, 0, 0, 0);
    ticks(4, DOOR_CLOSING, 0, 0, 0);
    tick(DOOR_CLOSED, 0, 0, 0);
    check_now("closing_expired", DOOR_CLOSED, 0, 0, 0);

    // Hall call in the wrong direction is ignored, matching direction opens.
    bus.cur_dir  = DIR_UP;
    bus.hall_btn = 2'b01;
    ticks(3, DOOR_CLOSED, 0, 0, 0);
    bus.hall_btn = 2'b10;
    tick(DOOR_OPENING, 1, 0, 0);
    bus.hall_btn = 2'b00;
    ticks(3, DOOR_OPENING, 0, 0, 0);
    ticks(2, DOOR_OPEN, 0, 0, 0);
    bus.close_btn = 1'b1;
    tick(DOOR_CLOSING, 0, 0, 0);
    bus.close_btn = 1'b0;
    ticks(3, DOOR_CLOSING, 0, 0, 0);
    tick(DOOR_CLOSED, 0, 0, 0);

    // Open button opens without served; obstruct beats close_btn.
    bus.open_btn = 1'b1;
    tick(DOOR_OPENING, 0, 0, 0);
    bus.open_btn = 1'b0;
    ticks(3, DOOR_OPENING, 0, 0, 0);
    tick(DOOR_OPEN, 0, 0, 0);
    bus.close_btn = 1'b1;
    bus.obstruct  = 1'b1;
    ticks(3, DOOR_OPEN, 0, 0, 0);
    bus.obstruct = 1'b0;
    tick(DOOR_CLOSING, 0, 0, 0);
    bus.close_btn = 1'b0;
    ticks(3, DOOR_CLOSING, 0, 0, 0);
    tick(DOOR_CLOSED, 0, 0, 0);

    // Two reversals, third obstruction forces a nudge close.
    bus.cur_dir  = DIR_STOP;
    bus.car_call = 7'b0001000;
    tick(DOOR_OPENING, 1, 0, 0);
    bus.car_call = '0;
    ticks(3, DOOR_OPENING, 0, 0, 0);
    ticks(10, DOOR_OPEN, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      tick(DOOR_CLOSING, 0, 0, 0);
      bus.obstruct = 1'b1;
      tick(DOOR_OPENING, 0, 0, 0);
      bus.obstruct = 1'b0;
      ticks(3, DOOR_OPENING, 0, 0, 0);
      ticks(10, DOOR_OPEN, 0, 0, 0);
    end
    tick(DOOR_CLOSING, 0, 0, 0);
    bus.obstruct = 1'b1;
    ticks(3, DOOR_CLOSING, 0, 1, 0);
    tick(DOOR_CLOSED, 0, 0, 0);
    bus.obstruct = 1'b0;

    // Out-of-range floor and illegal direction never produce a call.
    bus.cur_floor = 3'd7;
    bus.car_call  = 7'h7F;
    bus.hall_btn  = 2'b11;
    ticks(2, DOOR_CLOSED, 0, 0, 0);
    bus.cur_floor = 3'd3;
    bus.car_call  = '0;
    bus.cur_dir   = 2'b11;
    ticks(2, DOOR_CLOSED, 0, 0, 0);
    bus.cur_dir  = DIR_STOP;
    bus.hall_btn = 2'b01;
    tick(DOOR_OPENING, 1, 0, 0);
    bus.hall_btn = 2'b00;
    ticks(3, DOOR_OPENING, 0, 0, 0);

    // Moving while open trips the interlock.
    ticks(2, DOOR_OPEN, 0, 0, 0);
    bus.moving = 1'b1;
    ticks(4, DOOR_CLOSING, 0, 1, 1);
    tick(DOOR_CLOSED, 0, 0, 0);
    bus.car_call = 7'b0001000;
    ticks(2, DOOR_CLOSED, 0, 0, 0);
    bus.moving = 1'b0;
    tick(DOOR_OPENING, 1, 0, 0);

    // Reset mid-opening returns straight to CLOSED.
    bus.car_call = '0;
    reset = 1'b1;
    tick(DOOR_CLOSED, 0, 0, 0);
    reset = 1'b0;
    ticks(2, DOOR_CLOSED, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
